mem_port_arbiter: RTL

//  Shares the single-ported processor memory between the instruction-fetch requester (IF, fetch state)
//  and the data requester (DM, lw/sw/push/pop in memory state). Arbitrates round-robin, latches the

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch (IF) and
// data (DM) requesters; each access holds the strobes for MemLat cycles, then pulses DONE.
module mem_port_arbiter #(
  parameter int unsigned AddrW  = 26,
  parameter int unsigned DataW  = 32,
  parameter int unsigned MemLat = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             if_req_i,
  input  logic [AddrW-1:0] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_done_o,
  output logic [DataW-1:0] if_rdata_o,
  input  logic             dm_req_i,
  input  logic             dm_we_i,
  input  logic [AddrW-1:0] dm_addr_i,
  input  logic [DataW-1:0] dm_wdata_i,
  output logic             dm_gnt_o,
  output logic             dm_done_o,
  output logic [DataW-1:0] dm_rdata_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  input  logic [DataW-1:0] mem_rdata_i
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_dm_q, last_dm_d;
  logic             own_dm_q, own_dm_d;
  logic             we_q, we_d;
  logic             if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic             if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [DataW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [DataW-1:0] mem_wdata_q, mem_wdata_d;
  logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;

  logic grant_if, grant_dm, last_cnt;

  // On a tie the requester that did not own the port last wins.
  assign grant_dm = dm_req_i & (~if_req_i | ~last_dm_q);
  assign grant_if = if_req_i & ~grant_dm;
  assign last_cnt = (cnt_q == CntW'(MemLat - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (if_req_i || dm_req_i) state_d = StAccess;
      StAccess: if (last_cnt) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    own_dm_d    = own_dm_q;
    we_d        = we_q;
    if_gnt_d    = if_gnt_q;
    dm_gnt_d    = dm_gnt_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    unique case (state_q)
      StIdle: begin
        if (grant_if || grant_dm) begin
          own_dm_d    = grant_dm;
          last_dm_d   = grant_dm;
          we_d        = grant_dm & dm_we_i;
          if_gnt_d    = grant_if;
          dm_gnt_d    = grant_dm;
          mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = grant_dm ? dm_wdata_i : '0;
          mem_read_d  = ~(grant_dm & dm_we_i);
          mem_write_d = grant_dm & dm_we_i;
          cnt_d       = '0;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (last_cnt) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (own_dm_q) begin
            dm_done_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata_i;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end
      StDone: begin
        if_gnt_d = 1'b0;
        dm_gnt_d = 1'b0;
      end
      default: begin
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q       <= '0;
      last_dm_q   <= 1'b1;
      own_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      own_dm_q    <= own_dm_d;
      we_q        <= we_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_gnt_o    = dm_gnt_q;
  assign dm_done_o   = dm_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;

endmodule
